iter_muldiv: RTL
================

// Module: iter_muldiv
// PURPOSE
//  Iterative unsigned multiply/divide unit for the CPU datapath, one bit per cycle.
//  Produces a {hi, lo} result pair. lo_o/hi_o feed the write-back MUX_4to1 data inputs.
//  Controller stalls the PC while busy_o is high; the result holds until the next op completes.
// PARAMETERS
//  WIDTH  32  operand/result half width; >= 2
// PORTS
//  clk_i    in   1      clock, all state updates on rising edge
//  rst_i    in   1      reset, synchronous, active-low
//  start_i  in   1      launch op; sampled only in IDLE
//  op_i     in   1      0 = MULTU, 1 = DIVU; sampled with start_i
//  src1_i   in   WIDTH  multiplicand / dividend; sampled with start_i
//  src2_i   in   WIDTH  multiplier / divisor; sampled with start_i
//  busy_o   out  1      high while state == RUN
//  done_o   out  1      one-cycle pulse, high while state == DONE
//  hi_o     out  WIDTH  MULTU: product[2W-1:W]; DIVU: remainder
//  lo_o     out  WIDTH  MULTU: product[W-1:0];  DIVU: quotient
// BEHAVIOUR
//  Reset (rst_i==0 at edge): state=IDLE, count=0, hi_o=lo_o=0, busy_o=done_o=0.
//   Overrides everything, including mid-RUN; the partial result is discarded and hi/lo clear.
//  FSM: IDLE -> RUN (start_i=1 at edge; operands and op latched, count=0)
//       IDLE -> DONE (start_i=1, op_i=1, src2_i==0: divide-by-zero fast path)
//       RUN  -> RUN  while count < WIDTH-1 (one iteration per edge, count++)
//       RUN  -> DONE on the edge performing iteration WIDTH-1; hi_o/lo_o update on that edge
//       DONE -> IDLE unconditionally
//  Latency: start sampled at edge N -> done_o high in cycle after edge N+WIDTH.
//   Next start can be accepted at edge N+WIDTH+2.
//   Div-by-zero: done_o high after edge N.
//  start_i in RUN or DONE is ignored; no queueing.
//  Input changes after the sampling edge have no effect.
//  MULTU: shift-add over a 2W-bit accumulator, LSB of multiplier first.
//   Result is the exact 2W-bit product; no overflow.
//  DIVU: restoring division, MSB first, W-bit quotient, (W+1)-bit partial-remainder compare.
//  Div-by-zero: lo_o = all ones, hi_o = src1 (dividend).
//  hi_o/lo_o change only on the edge entering DONE, or on reset; otherwise they hold.
//  Outputs are registered or decoded from state only; no combinational path from inputs.
// STRUCTURE
//  Shared include muldiv_defs.vh: OP_MULTU/OP_DIVU encodings, and FSM state codes
//   ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
//  Sub-module muldiv_step (combinational): one iteration from {acc, opnd, op}, producing the next acc.
//   The top holds the FSM, counter and operand/acc registers.
// TESTING
//  MULTU 7 x 6 -> done_o after 32 RUN cycles; hi=0, lo=42; busy_o high exactly 32 cycles.
//  MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
//  DIVU 100 / 7 -> lo=14, hi=2. DIVU 5 / 9 -> lo=0, hi=5.
//  DIVU 0x1234 / 0 -> done_o one cycle after start, busy_o never high; lo=0xFFFFFFFF, hi=0x1234.
//  start_i held high plus operand change mid-RUN -> result still from the latched operands.
//   IDLE re-entry, and next op accepted only after DONE.
//  rst_i low at RUN count=10 -> next cycle IDLE, hi=lo=0, no done_o pulse.
//   A fresh MULTU 3 x 3 then returns lo=9.

Source files
------------

// File: rtl/iter_muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: opcodes and FSM state codes.
package iter_muldiv_pkg;

  localparam logic OP_MULTU = 1'b0;
  localparam logic OP_DIVU  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/iter_muldiv_step.sv
// One combinational iteration of the shared {hi, lo} accumulator:
// shift-add for MULTU, restoring subtract-and-shift for DIVU.
module iter_muldiv_step
  import iter_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH:0]   acc,
  input  logic [WIDTH-1:0]   opnd,
  input  logic               op,
  output logic [2*WIDTH:0]   acc_next
);

  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   rem_s;
  logic [WIDTH:0]   diff_s;
  logic [2*WIDTH:0] add_s;

  // Next accumulator for the selected operation
  always_comb begin
    sum_s    = acc[2*WIDTH:WIDTH] + {1'b0, opnd};
    rem_s    = acc[2*WIDTH-1:WIDTH-1];
    diff_s   = rem_s - {1'b0, opnd};
    add_s    = {1'b0, acc[2*WIDTH-1:0]};
    acc_next = acc;
    if (op == OP_MULTU) begin
      // Multiplier sits in the low half and is consumed LSB first as the product shifts in.
      if (acc[0]) begin
        add_s = {sum_s, acc[WIDTH-1:0]};
      end else begin
        add_s = {1'b0, acc[2*WIDTH-1:0]};
      end
      acc_next = add_s >> 1;
    end else begin
      // Dividend bits shift out of the low half MSB first; quotient bits shift in behind them.
      if (rem_s >= {1'b0, opnd}) begin
        acc_next = {diff_s, acc[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = {rem_s, acc[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/iter_muldiv.sv
// Iterative unsigned MULTU/DIVU unit, one bit per cycle; holds the FSM, counter and
// operand/accumulator registers around a combinational step.
module iter_muldiv
  import iter_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             op_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  state_t           state_r;
  state_t           state_s;
  logic [CW-1:0]    count_r;
  logic             op_r;
  logic [WIDTH-1:0] opnd_r;
  logic [2*WIDTH:0] acc_r;
  logic [2*WIDTH:0] acc_next_s;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic             last_s;
  logic             dbz_s;

  iter_muldiv_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .acc      (acc_r),
    .opnd     (opnd_r),
    .op       (op_r),
    .acc_next (acc_next_s)
  );

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode; divide-by-zero skips RUN entirely
  always_comb begin
    state_s = state_r;
    last_s  = (count_r == CW'(WIDTH - 1));
    dbz_s   = (op_i == OP_DIVU) && (src2_i == {WIDTH{1'b0}});
    case (state_r)
      ST_IDLE: begin
        if (start_i) begin
          if (dbz_s) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_RUN;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Operand latch, iteration and result capture
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      count_r <= {CW{1'b0}};
      op_r    <= OP_MULTU;
      opnd_r  <= {WIDTH{1'b0}};
      acc_r   <= {(2*WIDTH+1){1'b0}};
      hi_r    <= {WIDTH{1'b0}};
      lo_r    <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_i) begin
            count_r <= {CW{1'b0}};
            op_r    <= op_i;
            opnd_r  <= src2_i;
            acc_r   <= {{(WIDTH+1){1'b0}}, src1_i};
            if (dbz_s) begin
              hi_r <= src1_i;
              lo_r <= {WIDTH{1'b1}};
            end
          end
        end
        ST_RUN: begin
          acc_r   <= acc_next_s;
          count_r <= count_r + CW'(1'b1);
          if (last_s) begin
            hi_r <= acc_next_s[2*WIDTH-1:WIDTH];
            lo_r <= acc_next_s[WIDTH-1:0];
          end
        end
        default: begin
          count_r <= count_r;
        end
      endcase
    end
  end

  assign busy_o = (state_r == ST_RUN);
  assign done_o = (state_r == ST_DONE);
  assign hi_o   = hi_r;
  assign lo_o   = lo_r;

endmodule
